// File: rtl/crc5_pkg.sv
// crc5_pkg: shared constants, FSM states and the
// Gen2 CRC5 single-bit step (x^5+x^3+1).
package crc5_pkg;

  localparam logic [4:0] CRC5_PRESET = 5'b01001;
  localparam logic       MODE_CHECK  = 1'b0;
  localparam logic       MODE_GEN    = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_EMIT,
    S_DONE
  } state_e;

  function automatic logic [4:0] crc5_next(
    input logic [4:0] crc,
    input logic       b
  );
    logic x;
    x = b ^ crc[4];
    return {crc[3], crc[2] ^ x, crc[1], crc[0], x};
  endfunction

endpackage

// File: rtl/crc5_lfsr.sv
// crc5_lfsr: 5-bit CRC register, sync preset load
// (priority) and per-bit step enable.
import crc5_pkg::*;

module crc5_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic       b,
  output logic [4:0] crc
);

  logic [4:0] crc_q;
  logic [4:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (load)
      crc_d = CRC5_PRESET;
    else if (en)
      crc_d = crc5_next(crc_q, b);
  end

  always_ff @(posedge clk) begin
    if (reset)
      crc_q <= CRC5_PRESET;
    else
      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/crc5_seq.sv
// crc5_seq: CRC5 CHECK/GEN sequencer (IDLE/SHIFT/EMIT/DONE).
// CRC5_ERRCNT_EN adds the saturating failed-CHECK counter.
import crc5_pkg::*;

module crc5_seq #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             bit_in,
  input  logic             bit_in_valid,
  output logic             bit_in_ready,
  output logic             bit_out,
  output logic             bit_out_valid,
  input  logic             bit_out_ready,
  output logic             done,
  output logic             crc_ok,
  output logic [4:0]       crc_value,
  output logic [7:0]       err_count
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             ok_q, ok_d;

  logic       load;
  logic       in_xfer;
  logic       out_xfer;
  logic       res_ok;
  logic       leave;
  logic [4:0] crc;

  // a zero count must not advertise ready,
  // so len==0 consumes no bit
  assign bit_in_ready  = (state_q == S_SHIFT)
                       && (cnt_q != '0);
  assign bit_out_valid = (state_q == S_EMIT);
  assign in_xfer  = bit_in_valid & bit_in_ready;
  assign out_xfer = bit_out_valid & bit_out_ready;
  assign load     = start && (state_q == S_IDLE);
  assign res_ok   = (mode_q == MODE_CHECK)
                  && (crc == 5'd0);

  crc5_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .en    (in_xfer),
    .b     (bit_in),
    .crc   (crc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    ok_d    = ok_q;
    leave   = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = len;
          mode_d  = mode;
          ok_d    = 1'b0;
        end
      end
      (state_q == S_SHIFT): begin
        if (cnt_q == '0) begin
          leave = 1'b1;
        end else if (in_xfer) begin
          cnt_d = cnt_q - LEN_W'(1);
          leave = (cnt_q == LEN_W'(1));
        end
        if (leave) begin
          idx_d   = 3'd4;
          state_d = (mode_q == MODE_GEN)
                  ? S_EMIT : S_DONE;
        end
      end
      (state_q == S_EMIT): begin
        if (out_xfer) begin
          idx_d = idx_q - 3'd1;
          if (idx_q == 3'd0)
            state_d = S_DONE;
        end
      end
      (state_q == S_DONE): begin
        ok_d    = res_ok;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      mode_q  <= MODE_CHECK;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ok_q    <= ok_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign crc_value = crc;
  assign bit_out   = bit_out_valid & crc[idx_q];
  // result is visible in the done cycle itself,
  // then held from the flop
  assign crc_ok    = done ? res_ok : ok_q;

`ifdef CRC5_ERRCNT_EN
  logic [7:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (done && (mode_q == MODE_CHECK)
        && (crc != 5'd0) && (err_q != 8'hff))
      err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 8'd0;
    else
      err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_crc5_seq.sv
// tb_crc5_seq: scoreboard bench for crc5_seq,
// expected CRC bits/results queued at job start.
module tb_crc5_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode;
  logic [4:0] len;
  logic       busy;
  logic       bit_in;
  logic       bit_in_valid;
  logic       bit_in_ready;
  logic       bit_out;
  logic       bit_out_valid;
  logic       bit_out_ready;
  logic       done;
  logic       crc_ok;
  logic [4:0] crc_value;
  logic [7:0] err_count;

  int n_chk = 0;
  int n_err = 0;

  logic       exp_bits[$];
  logic       exp_ok[$];
  logic [4:0] exp_crc[$];
  logic [7:0] exp_err;

  crc5_seq #(.LEN_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .len           (len),
    .busy          (busy),
    .bit_in        (bit_in),
    .bit_in_valid  (bit_in_valid),
    .bit_in_ready  (bit_in_ready),
    .bit_out       (bit_out),
    .bit_out_valid (bit_out_valid),
    .bit_out_ready (bit_out_ready),
    .done          (done),
    .crc_ok        (crc_ok),
    .crc_value     (crc_value),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  // shift-left form of the Gen2 CRC5 LFSR
  function automatic logic [4:0] mdl(
    input logic [4:0] c,
    input logic       b
  );
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0}
         ^ (fb ? 5'b01001 : 5'b00000);
  endfunction

  task automatic run_job(
    input logic        m,
    input logic [4:0]  n,
    input logic [31:0] bits,
    input bit          stall
  );
    logic [4:0] c;
    int  fed;
    int  rdyc;
    int  emitted;
    int  hold;
    int  cyc;
    bit  fin;
    bit  bad;
    c = 5'b01001;
    fed = 0; rdyc = 0; emitted = 0;
    hold = 0; cyc = 0; fin = 0;
    for (int i = 0; i < int'(n); i++)
      c = mdl(c, bits[i]);
    if (m)
      for (int k = 4; k >= 0; k--)
        exp_bits.push_back(c[k]);
    exp_ok.push_back(m ? 1'b0 : (c == 5'd0));
    exp_crc.push_back(c);
    bad = !m && (c != 5'd0);

    @(negedge clk);
    start = 1'b1; mode = m; len = n;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);

    while (!fin && cyc < 300) begin
      if (done) begin
        chk("crc_ok", crc_ok, exp_ok.pop_front());
        chk("crc_val", crc_value,
            exp_crc.pop_front());
        chk("fed", fed, int'(n));
        chk("left", exp_bits.size(), 0);
        if (n == 5'd0)
          chk("rdy_len0", rdyc, 0);
        bit_in_valid = 1'b0;
        fin = 1;
      end else begin
        if (bit_in_ready) rdyc++;
        bit_in = bits[fed];
        bit_in_valid = (fed < int'(n))
          && ($urandom_range(0, 3) != 0);
        if (bit_in_ready && bit_in_valid)
          fed++;
        bit_out_ready = 1'b1;
        if (bit_out_valid) begin
          if (exp_bits.size() == 0) begin
            chk("extra_bit", 1, 0);
          end else if (stall && emitted == 2
                       && hold < 3) begin
            bit_out_ready = 1'b0;
            hold++;
            chk("hold_bit", bit_out, exp_bits[0]);
          end else begin
            chk("bit_out", bit_out,
                exp_bits.pop_front());
            emitted++;
          end
        end
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) begin
      chk("timeout", 0, 1);
      exp_bits.delete();
      exp_ok.delete();
      exp_crc.delete();
    end
    bit_in_valid  = 1'b0;
    bit_out_ready = 1'b1;
`ifdef CRC5_ERRCNT_EN
    if (bad && exp_err != 8'hff)
      exp_err++;
`else
    if (bad) exp_err = exp_err;
`endif
    @(negedge clk);
    chk("busy_off", busy, 0);
    chk("ok_held", crc_ok, m ? 1'b0 : (c == 5'd0));
    chk("err_cnt", err_count, exp_err);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    len = 5'd0; bit_in = 1'b0;
    bit_in_valid = 1'b0; bit_out_ready = 1'b1;
    exp_err = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_crc", crc_value, 5'b01001);
    chk("rst_err", err_count, 0);
    chk("rst_rdy", bit_in_ready, 0);
    chk("rst_ovld", bit_out_valid, 0);
    chk("rst_bout", bit_out, 0);
    reset = 1'b0;

    bit_in = 1'b1; bit_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_crc", crc_value, 5'b01001);
    chk("idle_busy", busy, 0);
    bit_in_valid = 1'b0;

    run_job(1'b1, 5'd1, 32'h0, 0);
    run_job(1'b0, 5'd6, 32'h12, 0);
    run_job(1'b0, 5'd6, 32'h32, 0);
    run_job(1'b1, 5'd0, 32'h0, 0);
    run_job(1'b1, 5'd5, 32'h0b, 1);
    for (int j = 0; j < 6; j++)
      run_job(1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)),
              $urandom, 1'($urandom_range(0, 1)));

    @(negedge clk);
    start = 1'b1; mode = 1'b0; len = 5'd6;
    @(negedge clk);
    start = 1'b0;
    bit_in = 1'b0; bit_in_valid = 1'b1;
    @(negedge clk);
    bit_in = 1'b1;
    @(negedge clk);
    bit_in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_rdy", bit_in_ready, 0);
    chk("ab_crc", crc_value, 5'b01001);
    chk("ab_err", err_count, 0);
    reset = 1'b0;
    exp_err = 8'd0;
    run_job(1'b0, 5'd6, 32'h12, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
